// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default register-file geometry and the
// register-file sequencer states.
package cpu_pkg;

  localparam int DEFAULT_DW    = 32;
  localparam int DEFAULT_DEPTH = 16;
  localparam int PC_REG        = DEFAULT_DEPTH - 1;

  typedef enum logic {
    INIT,
    RUN
  } rf_state_t;

endpackage

// File: rtl/rf_read_port.sv
// One registered read port: alias / range / write-bypass / array priority mux.
// Output is forced to zero while the owning register file is sweeping.
module rf_read_port
  import cpu_pkg::*;
#(
  parameter int DW       = DEFAULT_DW,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int AW       = $clog2(DEPTH),
  parameter int PC_ALIAS = 1
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          run_i,
  input  logic [AW-1:0] rd_addr_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] data_i,
  input  logic [DW-1:0] pc_i,
  input  logic [DW-1:0] regs_i [DEPTH],
  output logic [DW-1:0] rd_data_o
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_W   = (AW + 1)'(DEPTH);

  logic [DW-1:0] next_data;

  // The range test is done one bit wider so it stays meaningful when DEPTH is a power of two
  always_comb begin
    next_data = '0;
    if ((PC_ALIAS != 0) && (rd_addr_i == LAST_ADDR)) begin
      next_data = pc_i;
    end else if ({1'b0, rd_addr_i} >= DEPTH_W) begin
      next_data = '0;
    end else if (wr_en_i && (wr_addr_i == rd_addr_i)) begin
      next_data = data_i;
    end else begin
      next_data = regs_i[rd_addr_i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_data_o <= '0;
    end else if (!run_i) begin
      rd_data_o <= '0;
    end else begin
      rd_data_o <= next_data;
    end
  end

endmodule

// File: rtl/banked_register_file.sv
// Parametrised CPU register file with optional PC alias, write-first bypass
// and a hardware initialisation sweep after reset or on clear_i.
module banked_register_file
  import cpu_pkg::*;
#(
  parameter int DW        = DEFAULT_DW,
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int NUM_RD    = 2,
  parameter int PC_ALIAS  = 1,
  parameter int INIT_MODE = 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [NUM_RD*AW-1:0] rd_addr_i,
  output logic [NUM_RD*DW-1:0] rd_data_o,
  input  logic                 wr_en_i,
  input  logic [AW-1:0]        wr_addr_i,
  input  logic [DW-1:0]        data_i,
  input  logic [DW-1:0]        pc_i,
  input  logic                 clear_i,
  output logic                 busy_o
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_W   = (AW + 1)'(DEPTH);

  rf_state_t     state;
  logic [AW-1:0] cnt;
  logic [DW-1:0] regs [DEPTH];
  logic [DW-1:0] sweep_value;
  logic          run;

  assign run         = (state == RUN);
  assign sweep_value = (INIT_MODE != 0) ? DW'(cnt) : '0;

  // Sweep sequencer: a clear in either state restarts the sweep from entry 0
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state  <= INIT;
      cnt    <= '0;
      busy_o <= 1'b1;
    end else begin
      case (state)
        INIT: begin
          if (clear_i) begin
            cnt <= '0;
          end else if (cnt == LAST_ADDR) begin
            state  <= RUN;
            cnt    <= '0;
            busy_o <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          if (clear_i) begin
            state  <= INIT;
            cnt    <= '0;
            busy_o <= 1'b1;
          end
        end
        default: begin
          state  <= INIT;
          cnt    <= '0;
          busy_o <= 1'b1;
        end
      endcase
    end
  end

  // Storage has no reset; the sweep owns the write port until RUN
  always_ff @(posedge clk_i) begin
    if (state == INIT) begin
      regs[cnt] <= sweep_value;
    end else if (wr_en_i && !clear_i && ({1'b0, wr_addr_i} < DEPTH_W)) begin
      regs[wr_addr_i] <= data_i;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    rf_read_port #(
      .DW       (DW),
      .DEPTH    (DEPTH),
      .AW       (AW),
      .PC_ALIAS (PC_ALIAS)
    ) u_port (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .run_i     (run),
      .rd_addr_i (rd_addr_i[k*AW +: AW]),
      .wr_en_i   (wr_en_i),
      .wr_addr_i (wr_addr_i),
      .data_i    (data_i),
      .pc_i      (pc_i),
      .regs_i    (regs),
      .rd_data_o (rd_data_o[k*DW +: DW])
    );
  end

endmodule

// File: tb/tb_banked_register_file.sv
// Scoreboard bench for banked_register_file: three instances (default,
// PC_ALIAS=0, DEPTH=12) share one stimulus stream with hand-computed expectations.
module tb_banked_register_file;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rd_addr;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] data;
  logic [31:0] pc;
  logic        clear;

  logic [63:0] rd_a, rd_b, rd_c;
  logic        busy_a, busy_b, busy_c;

  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  typedef struct {
    int          due;
    int          kind;
    int          inst;
    int          port;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];

  banked_register_file u_a (
    .clk_i(clk), .rst_n_i(rst_n), .rd_addr_i(rd_addr), .rd_data_o(rd_a),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .data_i(data), .pc_i(pc),
    .clear_i(clear), .busy_o(busy_a)
  );

  banked_register_file #(.PC_ALIAS(0)) u_b (
    .clk_i(clk), .rst_n_i(rst_n), .rd_addr_i(rd_addr), .rd_data_o(rd_b),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .data_i(data), .pc_i(pc),
    .clear_i(clear), .busy_o(busy_b)
  );

  banked_register_file #(.DEPTH(12)) u_c (
    .clk_i(clk), .rst_n_i(rst_n), .rd_addr_i(rd_addr), .rd_data_o(rd_c),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .data_i(data), .pc_i(pc),
    .clear_i(clear), .busy_o(busy_c)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] get_actual(input int kind, input int inst, input int port);
    logic [63:0] rd;
    logic        bsy;
    case (inst)
      0:       begin rd = rd_a; bsy = busy_a; end
      1:       begin rd = rd_b; bsy = busy_b; end
      default: begin rd = rd_c; bsy = busy_c; end
    endcase
    if (kind == 1) return {31'd0, bsy};
    return (port == 0) ? rd[31:0] : rd[63:32];
  endfunction

  // Monitor: retires every expectation whose sample cycle has arrived
  logic [31:0] act;
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due <= cyc) begin
        act = get_actual(sb[i].kind, sb[i].inst, sb[i].port);
        total++;
        if (act !== sb[i].exp) begin
          bad++;
          $display("[TB] FAIL %s inst%0d port%0d: got %h want %h",
                   sb[i].name, sb[i].inst, sb[i].port, act, sb[i].exp);
        end
        sb.delete(i);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input int kind, input int inst, input int port,
                            input logic [31:0] exp, input int delay, input string name);
    exp_t e;
    e.due  = cyc + delay;
    e.kind = kind;
    e.inst = inst;
    e.port = port;
    e.exp  = exp;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic expect_rd(input int inst, input int port, input logic [31:0] exp, input string name);
    expect_val(0, inst, port, exp, 1, name);
  endtask

  task automatic expect_busy(input int inst, input logic bsy, input string name);
    expect_val(1, inst, 0, {31'd0, bsy}, 0, name);
  endtask

  task automatic apply_stimulus(input logic [3:0] p0, input logic [3:0] p1, input logic we,
                                input logic [3:0] wa, input logic [31:0] wd);
    rd_addr = {p1, p0};
    wr_en   = we;
    wr_addr = wa;
    data    = wd;
  endtask

  task automatic expect_reset_state(input string name);
    for (int n = 0; n < 3; n++) begin
      expect_val(1, n, 0, 32'd1, 0, name);
      expect_val(0, n, 0, 32'd0, 0, name);
      expect_val(0, n, 1, 32'd0, 0, name);
    end
  endtask

  // Walks one sweep; u_b follows u_a only when it was released together with it
  task automatic check_sweep(input string name, input logic check_b);
    for (int i = 0; i < 16; i++) begin
      expect_busy(0, 1'b1, name);
      if (check_b) expect_busy(1, 1'b1, name);
      expect_busy(2, (i < 12), name);
      if (i > 0) expect_val(0, 0, 0, 32'd0, 0, {name, "_rdzero"});
      tick();
    end
    expect_busy(0, 1'b0, {name, "_done"});
    if (check_b) expect_busy(1, 1'b0, {name, "_done"});
    expect_busy(2, 1'b0, {name, "_done"});
  endtask

  initial begin
    rst_n = 1'b0;
    pc    = 32'h0;
    clear = 1'b0;
    apply_stimulus(4'd0, 4'd0, 1'b0, 4'd0, 32'h0);
    tick();
    expect_reset_state("reset");
    tick();

    rst_n = 1'b1;
    apply_stimulus(4'd5, 4'd5, 1'b0, 4'd0, 32'h0);
    check_sweep("sweep_reset", 1'b1);

    apply_stimulus(4'd5, 4'd9, 1'b0, 4'd0, 32'h0);
    for (int n = 0; n < 3; n++) begin
      expect_rd(n, 0, 32'd5, "read_r5");
      expect_rd(n, 1, 32'd9, "read_r9");
    end
    tick();

    apply_stimulus(4'd3, 4'd0, 1'b1, 4'd3, 32'hDEADBEEF);
    for (int n = 0; n < 3; n++) begin
      expect_rd(n, 0, 32'hDEADBEEF, "bypass_r3");
      expect_rd(n, 1, 32'd0, "read_r0");
    end
    tick();
    apply_stimulus(4'd0, 4'd3, 1'b0, 4'd0, 32'h0);
    for (int n = 0; n < 3; n++) begin
      expect_rd(n, 1, 32'hDEADBEEF, "stored_r3");
      expect_rd(n, 0, 32'd0, "read_r0b");
    end
    tick();

    pc = 32'h100;
    apply_stimulus(4'd15, 4'd11, 1'b1, 4'd15, 32'h1234);
    expect_rd(0, 0, 32'h100, "alias_pc");
    expect_rd(1, 0, 32'h1234, "noalias_bypass");
    expect_rd(2, 0, 32'h0, "d12_oor_r15");
    expect_rd(0, 1, 32'd11, "read_r11");
    expect_rd(1, 1, 32'd11, "read_r11");
    expect_rd(2, 1, 32'h100, "d12_alias_r11");
    tick();
    pc = 32'h200;
    apply_stimulus(4'd15, 4'd11, 1'b0, 4'd0, 32'h0);
    expect_rd(0, 0, 32'h200, "alias_pc2");
    expect_rd(1, 0, 32'h1234, "noalias_stored");
    expect_rd(2, 0, 32'h0, "d12_oor_r15b");
    expect_rd(0, 1, 32'd11, "read_r11b");
    expect_rd(1, 1, 32'd11, "read_r11b");
    expect_rd(2, 1, 32'h200, "d12_alias_r11b");
    tick();

    apply_stimulus(4'd13, 4'd13, 1'b1, 4'd13, 32'h5555);
    for (int p = 0; p < 2; p++) begin
      expect_rd(0, p, 32'h5555, "bypass_r13");
      expect_rd(1, p, 32'h5555, "bypass_r13");
      expect_rd(2, p, 32'h0, "d12_oor_r13");
    end
    tick();

    for (int i = 0; i < 12; i++) begin
      apply_stimulus(4'(i), 4'(i), 1'b0, 4'd0, 32'h0);
      for (int p = 0; p < 2; p++) begin
        expect_rd(0, p, (i == 3) ? 32'hDEADBEEF : 32'(i), $sformatf("scan_r%0d", i));
        expect_rd(1, p, (i == 3) ? 32'hDEADBEEF : 32'(i), $sformatf("scan_r%0d", i));
        expect_rd(2, p, (i == 3) ? 32'hDEADBEEF : (i == 11) ? 32'h200 : 32'(i),
                  $sformatf("d12_scan_r%0d", i));
      end
      tick();
    end

    clear = 1'b1;
    apply_stimulus(4'd0, 4'd0, 1'b1, 4'd2, 32'hAA);
    tick();
    clear = 1'b0;
    apply_stimulus(4'd0, 4'd0, 1'b0, 4'd0, 32'h0);
    check_sweep("sweep_clear", 1'b0);
    apply_stimulus(4'd2, 4'd3, 1'b0, 4'd0, 32'h0);
    for (int n = 0; n < 3; n += 2) begin
      expect_rd(n, 0, 32'd2, "clear_r2");
      expect_rd(n, 1, 32'd3, "clear_r3");
    end
    tick();

    apply_stimulus(4'd5, 4'd5, 1'b0, 4'd0, 32'h0);
    tick();
    rst_n = 1'b0;
    expect_reset_state("reset_run");
    tick();
    rst_n = 1'b1;

    repeat (7) tick();
    apply_stimulus(4'd5, 4'd5, 1'b1, 4'd4, 32'hFFFF);
    tick();
    rst_n = 1'b0;
    expect_reset_state("reset_sweep");
    tick();
    rst_n = 1'b1;
    apply_stimulus(4'd5, 4'd5, 1'b0, 4'd0, 32'h0);
    check_sweep("sweep_rereset", 1'b1);

    for (int i = 0; i < 16; i++) begin
      apply_stimulus(4'(i), 4'(i), 1'b0, 4'd0, 32'h0);
      for (int p = 0; p < 2; p++) begin
        expect_rd(0, p, (i == 15) ? 32'h200 : 32'(i), $sformatf("final_r%0d", i));
        expect_rd(1, p, 32'(i), $sformatf("final_r%0d", i));
        expect_rd(2, p, (i < 11) ? 32'(i) : (i == 11) ? 32'h200 : 32'h0,
                  $sformatf("d12_final_r%0d", i));
      end
      tick();
    end

    apply_stimulus(4'd0, 4'd0, 1'b0, 4'd0, 32'h0);
    repeat (2) tick();
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
